// File: rtl/wallet_io_pkg.sv
// wallet_io_pkg: shared types and derived-constant helpers for the wallet input conditioner.
package wallet_io_pkg;
  typedef enum logic {INIT, RUN} top_state_t;
  typedef enum logic {STABLE, COUNT} db_state_t;
  function automatic int cnt_width(input int v);
    return $clog2(v + 1);
  endfunction
  function automatic int tick_cyc(input int clk_hz);
    return clk_hz / 1000;
  endfunction
  function automatic int db_cyc(input int clk_hz, input int ms);
    return tick_cyc(clk_hz) * ms;
  endfunction
endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser plus counting debouncer for one input bit.
module debounce_cell
  import wallet_io_pkg::*;
#(
  parameter int DB_CYC = 20,
  parameter bit INVERT = 1'b0
)(
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  input  logic run,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DB_CYC);
  db_state_t state, state_nx;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic sig, done;
  assign sig = sync[1] ^ INVERT;
  always_comb begin
    state_nx = state;
    done = 1'b0;
    if (run && state == STABLE) state_nx = (sig != level) ? COUNT : STABLE;
    else if (run) begin
      done = (sig != level) && (cnt == CW'(DB_CYC - 1));
      state_nx = (sig == level || done) ? STABLE : COUNT;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= STABLE;
    else state <= state_nx;
  // The initial load bypasses the counter and never produces edge pulses.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (state == STABLE) ? '0 : cnt + 1'b1;
      level <= (load || done) ? sig : level;
      rise <= done && sig;
      fall <= done && !sig;
    end
endmodule

// File: rtl/wallet_input_conditioner.sv
// wallet_input_conditioner: synchronises and debounces board buttons/switches,
// producing clean PIO levels plus press, release, long-press and change pulses.
module wallet_input_conditioner
  import wallet_io_pkg::*;
#(
  parameter int NUM_BUTTONS = 2,
  parameter int NUM_SWITCHES = 4,
  parameter int CLK_HZ = 50000000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter int BUTTON_ACTIVE_LOW = 1
)(
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw_i,
  input  logic [NUM_SWITCHES-1:0] sw_raw_i,
  output logic [NUM_BUTTONS-1:0] buttons_pi_export_o,
  output logic [NUM_SWITCHES-1:0] switch_pi_export_o,
  output logic [NUM_BUTTONS-1:0] btn_press_o,
  output logic [NUM_BUTTONS-1:0] btn_release_o,
  output logic [NUM_BUTTONS-1:0] btn_long_o,
  output logic [NUM_SWITCHES-1:0] sw_change_o,
  output logic init_done_o
);
  localparam int TICK_CYC = tick_cyc(CLK_HZ);
  localparam int DB_CYC = db_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int DW = cnt_width(DB_CYC);
  localparam int TW = cnt_width(TICK_CYC);
  localparam int LW = cnt_width(LONG_PRESS_MS);
  if (TICK_CYC < 1 || DEBOUNCE_MS < 1) begin : g_bad_cfg
    $error("wallet_input_conditioner: CLK_HZ must be >= 1000 and DEBOUNCE_MS >= 1");
  end
  top_state_t state, state_nx;
  logic [DW-1:0] init_cnt;
  logic [TW-1:0] pre;
  logic load, run, ms_tick;
  logic [NUM_SWITCHES-1:0] sw_rise, sw_fall;
  always_comb begin
    load = (state == INIT) && (init_cnt == DW'(DB_CYC - 1));
    state_nx = load ? RUN : state;
  end
  assign run = (state == RUN);
  assign ms_tick = (pre == TW'(TICK_CYC - 1));
  assign sw_change_o = sw_rise | sw_fall;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) state <= INIT;
    else state <= state_nx;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      init_cnt <= '0;
      init_done_o <= 1'b0;
      pre <= '0;
    end else begin
      init_cnt <= (state == INIT && !load) ? init_cnt + 1'b1 : init_cnt;
      init_done_o <= init_done_o || load;
      pre <= ms_tick ? '0 : pre + 1'b1;
    end
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic [LW-1:0] cnt;
    logic long_q;
    debounce_cell #(.DB_CYC(DB_CYC), .INVERT(BUTTON_ACTIVE_LOW != 0)) u_cell (
      .clk(clk_clk), .rst_n(reset_reset_n), .raw(btn_raw_i[i]), .load(load), .run(run),
      .level(buttons_pi_export_o[i]), .rise(btn_press_o[i]), .fall(btn_release_o[i])
    );
    // Counter saturates at the threshold so the long pulse fires once per press.
    always_ff @(posedge clk_clk or negedge reset_reset_n)
      if (!reset_reset_n) begin
        cnt <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= ms_tick && buttons_pi_export_o[i] && cnt == LW'(LONG_PRESS_MS - 1);
        cnt <= !buttons_pi_export_o[i] ? '0 :
               (ms_tick && cnt != LW'(LONG_PRESS_MS)) ? cnt + 1'b1 : cnt;
      end
    // Masking with the level lets a coincident release win over the long pulse.
    assign btn_long_o[i] = long_q && buttons_pi_export_o[i];
  end
  for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_sw
    debounce_cell #(.DB_CYC(DB_CYC), .INVERT(1'b0)) u_cell (
      .clk(clk_clk), .rst_n(reset_reset_n), .raw(sw_raw_i[i]), .load(load), .run(run),
      .level(switch_pi_export_o[i]), .rise(sw_rise[i]), .fall(sw_fall[i])
    );
  end
endmodule

// File: tb/tb_wallet_input_conditioner.sv
// tb_wallet_input_conditioner: table vectors plus hand sequences; pulses are
// checked against a scoreboard of expected (kind, index, cycle window) events.
module tb_wallet_input_conditioner;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] btn;
  logic [3:0] sw;
  logic [1:0] lvl_b, press, release_p, long_p;
  logic [3:0] lvl_s, change;
  logic init_done;
  typedef struct {int kind; int idx; int lo; int hi;} exp_t;
  typedef struct {logic [1:0] btn; logic [3:0] sw; logic [1:0] exp_b; logic [3:0] exp_s;} vec_t;
  exp_t sbq[$];
  vec_t vecs[7];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int t;
  logic [1:0] prev_b;
  logic [3:0] prev_s;
  string kname[4] = '{"press", "release", "long", "change"};
  always #5 clk = ~clk;
  wallet_input_conditioner #(
    .NUM_BUTTONS(2), .NUM_SWITCHES(4), .CLK_HZ(10000), .DEBOUNCE_MS(2),
    .LONG_PRESS_MS(5), .BUTTON_ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .btn_raw_i(btn), .sw_raw_i(sw),
    .buttons_pi_export_o(lvl_b), .switch_pi_export_o(lvl_s), .btn_press_o(press),
    .btn_release_o(release_p), .btn_long_o(long_p), .sw_change_o(change),
    .init_done_o(init_done)
  );
  function automatic logic [3:0] pulses(input int k);
    return k == 0 ? {2'b00, press} : k == 1 ? {2'b00, release_p} :
           k == 2 ? {2'b00, long_p} : change;
  endfunction
  task automatic push(input int kind, input int idx, input int lo, input int hi);
    exp_t e;
    e.kind = kind; e.idx = idx; e.lo = lo; e.hi = hi;
    sbq.push_back(e);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  task automatic scan();
    logic [3:0] p;
    int hit;
    for (int k = 0; k < 4; k++) begin
      p = pulses(k);
      for (int i = 0; i < 4; i++) if (p[i]) begin
        hit = -1;
        foreach (sbq[j])
          if (hit < 0 && sbq[j].kind == k && sbq[j].idx == i && sbq[j].lo <= cyc && sbq[j].hi >= cyc) hit = j;
        compared++;
        if (hit >= 0) sbq.delete(hit);
        else begin
          mismatched++;
          $display("FAIL pulse_%s[%0d]: got pulse at cycle %0d, required none", kname[k], i, cyc);
        end
      end
    end
    for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].hi < cyc) begin
      compared++;
      mismatched++;
      $display("FAIL pulse_%s[%0d]: got no pulse, required one in cycles %0d..%0d",
               kname[sbq[j].kind], sbq[j].idx, sbq[j].lo, sbq[j].hi);
      sbq.delete(j);
    end
  endtask
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cyc++;
      scan();
    end
  endtask
  function automatic logic [16:0] all_out();
    return {lvl_b, lvl_s, press, release_p, long_p, change, init_done};
  endfunction
  initial begin
    vecs[0] = '{2'b11, 4'b0101, 2'b00, 4'b0101};
    vecs[1] = '{2'b10, 4'b0101, 2'b01, 4'b0101};
    vecs[2] = '{2'b11, 4'b1111, 2'b00, 4'b1111};
    vecs[3] = '{2'b01, 4'b0000, 2'b10, 4'b0000};
    vecs[4] = '{2'b11, 4'b0110, 2'b00, 4'b0110};
    vecs[5] = '{2'b00, 4'b0110, 2'b11, 4'b0110};
    vecs[6] = '{2'b11, 4'b1010, 2'b00, 4'b1010};
    rst_n = 1'b0; btn = 2'b11; sw = 4'b1010;
    step(3);
    check("reset_outputs", 32'(all_out()), 0);
    rst_n = 1'b1; t = cyc;
    step(19);
    check("init_done_early", 32'(init_done), 0);
    step(1);
    check("init_done_at_20", 32'(init_done), 1);
    check("init_sw_level", 32'(lvl_s), 32'b1010);
    check("init_btn_level", 32'(lvl_b), 0);
    prev_b = 2'b00; prev_s = 4'b1010;
    step(5);
    foreach (vecs[v]) begin
      btn = vecs[v].btn; sw = vecs[v].sw; t = cyc;
      for (int i = 0; i < 2; i++)
        if (vecs[v].exp_b[i] != prev_b[i]) push(vecs[v].exp_b[i] ? 0 : 1, i, t + 23, t + 23);
      for (int i = 0; i < 4; i++)
        if (vecs[v].exp_s[i] != prev_s[i]) push(3, i, t + 23, t + 23);
      prev_b = vecs[v].exp_b; prev_s = vecs[v].exp_s;
      step(30);
      check($sformatf("vec%0d_btn", v), 32'(lvl_b), 32'(vecs[v].exp_b));
      check($sformatf("vec%0d_sw", v), 32'(lvl_s), 32'(vecs[v].exp_s));
    end
    btn[0] = 1'b0; t = cyc;
    push(0, 0, t + 23, t + 23);
    push(2, 0, t + 63, t + 83);
    step(22);
    check("btn0_before_accept", 32'(lvl_b[0]), 0);
    step(1);
    check("btn0_accept_23", 32'(lvl_b[0]), 1);
    check("btn0_press_pulse", 32'(press[0]), 1);
    step(80);
    btn[0] = 1'b1; t = cyc;
    push(1, 0, t + 23, t + 23);
    step(30);
    check("btn0_released", 32'(lvl_b[0]), 0);
    for (int k = 0; k < 13; k++) begin
      btn[1] = ~btn[1];
      if (k < 12) step(5);
    end
    t = cyc;
    push(0, 1, t + 23, t + 23);
    step(22);
    check("btn1_bounce_level", 32'(lvl_b[1]), 0);
    step(11);
    check("btn1_bounce_accept", 32'(lvl_b[1]), 1);
    btn[1] = 1'b1; t = cyc;
    push(1, 1, t + 23, t + 23);
    step(30);
    btn[0] = 1'b0; sw[2] = ~sw[2]; t = cyc;
    push(0, 0, t + 23, t + 23);
    push(3, 2, t + 23, t + 23);
    step(23);
    check("simul_press_change", 32'({press[0], change[2]}), 32'b11);
    step(10);
    btn[0] = 1'b1; t = cyc;
    push(1, 0, t + 23, t + 23);
    step(30);
    check("sb_drained", 32'(sbq.size()), 0);
    btn[1] = 1'b0;
    step(10);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(all_out()), 0);
    step(3);
    check("held_reset_outputs", 32'(all_out()), 0);
    rst_n = 1'b1;
    step(19);
    check("reinit_done_early", 32'(init_done), 0);
    step(1);
    check("reinit_done", 32'(init_done), 1);
    check("reinit_btn_level", 32'(lvl_b), 32'b10);
    check("reinit_sw_level", 32'(lvl_s), 32'b1110);
    btn[1] = 1'b1; t = cyc;
    push(1, 1, t + 23, t + 23);
    step(40);
    check("sb_empty", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
